// File: rtl/serial_shift_link_pkg.sv
// Shared types and constants for the VIA-style serial shift link.
package serial_shift_link_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TX      = 2'd1,
    WAIT_RX = 2'd2,
    RX      = 2'd3
  } linkState_e;

  localparam logic MODE_KBD = 1'b0;
  localparam logic MODE_ADB = 1'b1;
  localparam int   HP_PLUS  = 1300;
  localparam int   HP_ADB   = 80;

endpackage

// File: rtl/serial_shift_link_rx_fifo.sv
// Device-to-host byte queue; a simultaneous push and pop is accepted even when full.
module link_rx_fifo import serial_shift_link_pkg::*; #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk32,
  input  logic                          reset,
  input  logic                          push,
  input  logic [DATA_BITS-1:0]          pushData,
  input  logic                          pop,
  output logic [DATA_BITS-1:0]          head,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     rdPtr;
  logic [PTR_W-1:0]     wrPtr;
  logic                 full;
  logic                 doPush;
  logic                 doPop;

  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty  = (count == '0);
  assign full   = (count == CNT_W'(FIFO_DEPTH));
  assign doPop  = pop & ~empty;
  assign doPush = push & (~full | doPop);
  assign head   = mem[rdPtr];

  always_ff @(posedge clk32) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

  always_ff @(posedge clk32 or posedge reset) begin
    if (reset) begin
      rdPtr    <= '0;
      wrPtr    <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (doPush) wrPtr <= nextPtr(wrPtr);
      if (doPop)  rdPtr <= nextPtr(rdPtr);
      if (doPush && !doPop)      count <= count + 1'b1;
      else if (doPop && !doPush) count <= count - 1'b1;
      if (push && !doPush) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/serial_shift_link.sv
// Keyboard/ADB serial shift link: clocks host frames in on CB1/CB2 and queued device bytes out.
module serial_shift_link import serial_shift_link_pkg::*; #(
  parameter int DATA_BITS  = 8,
  parameter int DIV_W      = 12,
  parameter int FIFO_DEPTH = 4,
  parameter int TMO_W      = 16
) (
  input  logic                        clk32,
  input  logic                        reset,
  input  logic                        clk_en,
  input  logic                        mode,
  input  logic [DIV_W-1:0]            half_period,
  input  logic [TMO_W-1:0]            tmo_limit,
  input  logic                        host_dat,
  input  logic                        start,
  output logic                        shift_clk,
  output logic                        shift_dat,
  output logic                        busy,
  output logic [DATA_BITS-1:0]        tx_data,
  output logic                        tx_strobe,
  input  logic [DATA_BITS-1:0]        rx_data,
  input  logic                        rx_strobe,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow,
  output logic                        timeout
);

  localparam int CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

  linkState_e           state, stateNext;
  logic [DIV_W-1:0]     divider, dividerNext;
  logic [CNT_W-1:0]     bitCnt, bitCntNext;
  logic [DATA_BITS-1:0] shiftReg, shiftRegNext, txDataNext;
  logic [TMO_W-1:0]     tmoCnt, tmoCntNext;
  logic                 shiftClkNext, shiftDatNext, txStrobeNext, timeoutNext;
  logic                 frameMode, frameModeNext, startPrev;
  logic                 fifoEmpty, popReq, toggle;
  logic [DATA_BITS-1:0] fifoHead;

  link_rx_fifo #(.DATA_BITS(DATA_BITS), .FIFO_DEPTH(FIFO_DEPTH)) rxFifo (
    .clk32    (clk32),
    .reset    (reset),
    .push     (clk_en & rx_strobe),
    .pushData (rx_data),
    .pop      (clk_en & popReq),
    .head     (fifoHead),
    .empty    (fifoEmpty),
    .count    (fifo_count),
    .overflow (overflow)
  );

  assign busy   = (state != IDLE);
  assign toggle = (divider == half_period);

  always_ff @(posedge clk32 or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      divider   <= '0;
      bitCnt    <= '0;
      shiftReg  <= '0;
      tmoCnt    <= '0;
      shift_clk <= 1'b1;
      shift_dat <= 1'b1;
      tx_data   <= '0;
      tx_strobe <= 1'b0;
      timeout   <= 1'b0;
      frameMode <= MODE_KBD;
      startPrev <= 1'b0;
    end else if (clk_en) begin
      state     <= stateNext;
      divider   <= dividerNext;
      bitCnt    <= bitCntNext;
      shiftReg  <= shiftRegNext;
      tmoCnt    <= tmoCntNext;
      shift_clk <= shiftClkNext;
      shift_dat <= shiftDatNext;
      tx_data   <= txDataNext;
      tx_strobe <= txStrobeNext;
      timeout   <= timeoutNext;
      frameMode <= frameModeNext;
      startPrev <= start;
    end
  end

  // The mode seen on the tick that leaves IDLE governs the whole frame.
  always_comb begin
    stateNext     = state;
    dividerNext   = divider;
    bitCntNext    = bitCnt;
    shiftRegNext  = shiftReg;
    tmoCntNext    = tmoCnt;
    shiftClkNext  = shift_clk;
    shiftDatNext  = shift_dat;
    txDataNext    = tx_data;
    txStrobeNext  = 1'b0;
    timeoutNext   = 1'b0;
    frameModeNext = frameMode;
    popReq        = 1'b0;
    unique case (state)
      IDLE: begin
        dividerNext   = '0;
        bitCntNext    = '0;
        tmoCntNext    = '0;
        shiftClkNext  = 1'b1;
        shiftDatNext  = 1'b1;
        frameModeNext = mode;
        if (mode == MODE_KBD) begin
          if (!host_dat) stateNext = TX;
        end else if (start && !startPrev) begin
          stateNext = TX;
        end else if (!fifoEmpty) begin
          stateNext = RX;
        end
      end
      TX, RX: begin
        if (!toggle) begin
          dividerNext = divider + 1'b1;
        end else begin
          dividerNext  = '0;
          shiftClkNext = ~shift_clk;
          if (shift_clk) begin
            if (state == TX) shiftRegNext = {shiftReg[DATA_BITS-2:0], host_dat};
            else             shiftDatNext = fifoHead[LAST_BIT - bitCnt];
          end else if (bitCnt == LAST_BIT) begin
            bitCntNext = '0;
            if (state == TX) begin
              txDataNext   = shiftReg;
              txStrobeNext = 1'b1;
              stateNext    = (frameMode == MODE_KBD) ? WAIT_RX : IDLE;
            end else begin
              popReq       = 1'b1;
              shiftDatNext = 1'b1;
              stateNext    = IDLE;
            end
          end else begin
            bitCntNext = bitCnt + 1'b1;
          end
        end
      end
      // A host reply that arrives on the expiry tick still wins over the timeout.
      WAIT_RX: begin
        if (host_dat && !fifoEmpty) begin
          stateNext  = RX;
          tmoCntNext = '0;
        end else if (tmo_limit != '0) begin
          if (tmoCnt == tmo_limit - 1'b1) begin
            stateNext   = IDLE;
            timeoutNext = 1'b1;
            tmoCntNext  = '0;
          end else begin
            tmoCntNext = tmoCnt + 1'b1;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

endmodule
